ddr2_dev_cmd_receiver: RTL and testbench

//  Device-side receiver for the DDR2 command bus driven by the controller. Sits on
//  the memory end of ddr_* and decodes CS/RAS/CAS/WE/BA/A every clk. Tracks per-bank

---
 rtl/ddr2_dev_cmd_receiver.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ddr2_dev_cmd_receiver.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_dev_cmd_receiver.sv
// DDR2 device-side command receiver: decodes the command bus, tracks per-bank rows and
// timing, flags protocol violations and emits CL/WL-aligned BL4 data-phase strobes.
module ddr2_dev_cmd_receiver #(
    parameter int NBANK      = 8,
    parameter int ROW_W      = 14,
    parameter int COL_W      = 10,
    parameter int T_RCD      = 3,
    parameter int T_RP       = 3,
    parameter int T_RAS      = 8,
    parameter int T_RFC      = 26,
    parameter int CL_DEFAULT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ddr_cke,
    input  logic                     ddr_cs_n,
    input  logic                     ddr_ras_n,
    input  logic                     ddr_cas_n,
    input  logic                     ddr_we_n,
    input  logic [$clog2(NBANK)-1:0] ddr_ba,
    input  logic [ROW_W-1:0]         ddr_a,
    output logic [NBANK-1:0]         bank_open,
    output logic [5:0]               cmd_strb,
    output logic                     rd_valid,
    output logic                     wr_valid,
    output logic [$clog2(NBANK)-1:0] xfer_ba,
    output logic [ROW_W-1:0]         xfer_row,
    output logic [COL_W-1:0]         xfer_col,
    output logic [2:0]               cur_cl,
    output logic                     err_valid,
    output logic [3:0]               err_code
);
    localparam int BA_W  = $clog2(NBANK);
    localparam int TW    = 8;
    localparam int DEPTH = 8;

    typedef enum logic [2:0] {
        C_NOP, C_ACT, C_RD, C_WR, C_PRE, C_REF, C_MRS
    } cmd_e;

    typedef struct packed {
        logic             vld;
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } beat_t;

    function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    // Second BL4 beat stays inside the aligned 4-column block.
    function automatic logic [COL_W-1:0] burst_col2(input logic [COL_W-1:0] base);
        return base ^ COL_W'(2);
    endfunction

    cmd_e             cmd;
    logic [NBANK-1:0] open_q, open_d;
    logic [ROW_W-1:0] row_q [NBANK];
    logic [ROW_W-1:0] row_d [NBANK];
    logic [TW-1:0]    rcd_q [NBANK];
    logic [TW-1:0]    rcd_d [NBANK];
    logic [TW-1:0]    rp_q  [NBANK];
    logic [TW-1:0]    rp_d  [NBANK];
    logic [TW-1:0]    ras_q [NBANK];
    logic [TW-1:0]    ras_d [NBANK];
    logic [TW-1:0]    rfc_q, rfc_d;
    logic             ccd_q, ccd_d;
    logic [2:0]       cl_q, cl_d;
    logic [5:0]       strb_q, strb_d;
    logic             err_vld_q, err_vld_d;
    logic [3:0]       err_code_q, err_code_d;
    beat_t            rd_q [DEPTH];
    beat_t            rd_d [DEPTH];
    beat_t            wr_q [DEPTH];
    beat_t            wr_d [DEPTH];

    logic [NBANK-1:0] pre_mask;
    logic             pre_ras_bad;
    logic             rp_all_zero;
    logic [2:0]       mrs_cl;
    logic             mrs_cl_ok;
    logic [3:0]       viol_code;
    logic             accept;
    beat_t            beat0, beat1;

    always_comb begin
        cmd = C_NOP;
        if (ddr_cke && !ddr_cs_n) begin
            case ({ddr_ras_n, ddr_cas_n, ddr_we_n})
                3'b011:  cmd = C_ACT;
                3'b101:  cmd = C_RD;
                3'b100:  cmd = C_WR;
                3'b010:  cmd = C_PRE;
                3'b001:  cmd = C_REF;
                3'b000:  cmd = C_MRS;
                default: cmd = C_NOP;
            endcase
        end
    end

    always_comb begin
        pre_mask         = '0;
        pre_mask[ddr_ba] = 1'b1;
        if (ddr_a[10]) begin
            pre_mask = '1;
        end
        pre_ras_bad = 1'b0;
        rp_all_zero = 1'b1;
        for (int i = 0; i < NBANK; i++) begin
            if (pre_mask[i] && open_q[i] && (ras_q[i] != '0)) begin
                pre_ras_bad = 1'b1;
            end
            if (rp_q[i] != '0) begin
                rp_all_zero = 1'b0;
            end
        end
        mrs_cl    = ddr_a[6:4];
        mrs_cl_ok = (mrs_cl >= 3'd3) && (mrs_cl <= 3'd6);
    end

    // Refresh lockout outranks every per-command check; otherwise the lowest code wins.
    always_comb begin
        viol_code = 4'd0;
        if ((cmd != C_NOP) && (rfc_q != '0)) begin
            viol_code = 4'd7;
        end else begin
            case (cmd)
                C_ACT: begin
                    if (open_q[ddr_ba])             viol_code = 4'd1;
                    else if (rp_q[ddr_ba] != '0)    viol_code = 4'd2;
                end
                C_RD, C_WR: begin
                    if (!open_q[ddr_ba])            viol_code = 4'd3;
                    else if (rcd_q[ddr_ba] != '0)   viol_code = 4'd4;
                    else if (ccd_q)                 viol_code = 4'd8;
                end
                C_PRE: begin
                    if (pre_ras_bad)                viol_code = 4'd5;
                end
                C_REF: begin
                    if ((|open_q) || !rp_all_zero)  viol_code = 4'd6;
                end
                C_MRS: begin
                    if ((ddr_ba == '0) && !mrs_cl_ok) viol_code = 4'd9;
                end
                default: viol_code = 4'd0;
            endcase
        end
        accept = (cmd != C_NOP) && (viol_code == 4'd0);
    end

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        rfc_d  = sat_dec(rfc_q);
        ccd_d  = 1'b0;
        cl_d   = cl_q;
        strb_d = '0;
        for (int i = 0; i < NBANK; i++) begin
            rcd_d[i] = sat_dec(rcd_q[i]);
            rp_d[i]  = sat_dec(rp_q[i]);
            ras_d[i] = sat_dec(ras_q[i]);
        end
        if (accept) begin
            case (cmd)
                C_ACT: begin
                    open_d[ddr_ba] = 1'b1;
                    row_d[ddr_ba]  = ddr_a;
                    rcd_d[ddr_ba]  = TW'(T_RCD - 1);
                    ras_d[ddr_ba]  = TW'(T_RAS - 1);
                    strb_d         = 6'b000001;
                end
                C_RD: begin
                    ccd_d  = 1'b1;
                    strb_d = 6'b000010;
                end
                C_WR: begin
                    ccd_d  = 1'b1;
                    strb_d = 6'b000100;
                end
                C_PRE: begin
                    for (int i = 0; i < NBANK; i++) begin
                        if (pre_mask[i] && open_q[i]) begin
                            open_d[i] = 1'b0;
                            rp_d[i]   = TW'(T_RP - 1);
                        end
                    end
                    strb_d = 6'b001000;
                end
                C_REF: begin
                    rfc_d  = TW'(T_RFC - 1);
                    strb_d = 6'b010000;
                end
                C_MRS: begin
                    if (ddr_ba == '0) begin
                        cl_d = mrs_cl;
                    end
                    strb_d = 6'b100000;
                end
                default: strb_d = '0;
            endcase
        end
        err_vld_d  = (viol_code != 4'd0);
        err_code_d = viol_code;
    end

    // Data-phase delay lines: entry i reaches the output i edges later, so a beat
    // scheduled at index CL-1 (read) or CL-2 (write) lands on the required cycle.
    always_comb begin
        beat0.vld = 1'b1;
        beat0.ba  = ddr_ba;
        beat0.row = row_q[ddr_ba];
        beat0.col = ddr_a[COL_W-1:0];
        beat1     = beat0;
        beat1.col = burst_col2(ddr_a[COL_W-1:0]);
        for (int i = 0; i < DEPTH - 1; i++) begin
            rd_d[i] = rd_q[i+1];
            wr_d[i] = wr_q[i+1];
        end
        rd_d[DEPTH-1] = '0;
        wr_d[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (accept && (cmd == C_RD)) begin
                if (i == int'(cl_q) - 1) rd_d[i] = beat0;
                if (i == int'(cl_q))     rd_d[i] = beat1;
            end
            if (accept && (cmd == C_WR)) begin
                if (i == int'(cl_q) - 2) wr_d[i] = beat0;
                if (i == int'(cl_q) - 1) wr_d[i] = beat1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            open_q     <= '0;
            rfc_q      <= '0;
            ccd_q      <= 1'b0;
            cl_q       <= 3'(CL_DEFAULT);
            strb_q     <= '0;
            err_vld_q  <= 1'b0;
            err_code_q <= '0;
            for (int i = 0; i < NBANK; i++) begin
                row_q[i] <= '0;
                rcd_q[i] <= '0;
                rp_q[i]  <= '0;
                ras_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
                wr_q[i] <= '0;
            end
        end else begin
            open_q     <= open_d;
            row_q      <= row_d;
            rcd_q      <= rcd_d;
            rp_q       <= rp_d;
            ras_q      <= ras_d;
            rfc_q      <= rfc_d;
            ccd_q      <= ccd_d;
            cl_q       <= cl_d;
            strb_q     <= strb_d;
            err_vld_q  <= err_vld_d;
            err_code_q <= err_code_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    // On a read/write collision the shared xfer_* bus reports the read.
    assign bank_open = open_q;
    assign cmd_strb  = strb_q;
    assign cur_cl    = cl_q;
    assign err_valid = err_vld_q;
    assign err_code  = err_code_q;
    assign rd_valid  = rd_q[0].vld;
    assign wr_valid  = wr_q[0].vld;
    assign xfer_ba   = rd_q[0].vld ? rd_q[0].ba  : wr_q[0].ba;
    assign xfer_row  = rd_q[0].vld ? rd_q[0].row : wr_q[0].row;
    assign xfer_col  = rd_q[0].vld ? rd_q[0].col : wr_q[0].col;

endmodule

// File: tb/tb_ddr2_dev_cmd_receiver.sv
// Bench for ddr2_dev_cmd_receiver: directed scenarios plus random command traffic
// checked every cycle against a time-stamp based reference model.
module tb_ddr2_dev_cmd_receiver;
    localparam int NBANK = 8, ROW_W = 14, COL_W = 10;
    localparam int T_RCD = 3, T_RP = 3, T_RAS = 8, T_RFC = 26, CL_DEFAULT = 4;
    localparam int MAXC = 8192;
    localparam int C_NOP = 0, C_ACT = 1, C_RD = 2, C_WR = 3, C_PRE = 4, C_REF = 5, C_MRS = 6;
    localparam int FAR = -1000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ddr_cke = 1'b0;
    logic             ddr_cs_n = 1'b1, ddr_ras_n = 1'b1, ddr_cas_n = 1'b1, ddr_we_n = 1'b1;
    logic [2:0]       ddr_ba = '0;
    logic [ROW_W-1:0] ddr_a = '0;
    logic [NBANK-1:0] bank_open;
    logic [5:0]       cmd_strb;
    logic             rd_valid, wr_valid, err_valid;
    logic [2:0]       xfer_ba, cur_cl;
    logic [ROW_W-1:0] xfer_row;
    logic [COL_W-1:0] xfer_col;
    logic [3:0]       err_code;

    ddr2_dev_cmd_receiver dut (
        .clk(clk), .rst_n(rst_n), .ddr_cke(ddr_cke), .ddr_cs_n(ddr_cs_n),
        .ddr_ras_n(ddr_ras_n), .ddr_cas_n(ddr_cas_n), .ddr_we_n(ddr_we_n),
        .ddr_ba(ddr_ba), .ddr_a(ddr_a), .bank_open(bank_open), .cmd_strb(cmd_strb),
        .rd_valid(rd_valid), .wr_valid(wr_valid), .xfer_ba(xfer_ba), .xfer_row(xfer_row),
        .xfer_col(xfer_col), .cur_cl(cur_cl), .err_valid(err_valid), .err_code(err_code)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, cyc = 0;

    // Reference state: time stamps of the last relevant commands per bank.
    bit m_open [NBANK];
    int m_row [NBANK], m_last_act [NBANK], m_last_pre [NBANK];
    int m_last_ref, m_last_rw, m_cl;
    int e_strb [MAXC], e_err [MAXC];
    bit e_rdv [MAXC], e_wrv [MAXC];
    int e_rba [MAXC], e_rrow [MAXC], e_rcol [MAXC];
    int e_wba [MAXC], e_wrow [MAXC], e_wcol [MAXC];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NBANK; b++) begin
            m_open[b] = 0; m_row[b] = 0; m_last_act[b] = FAR; m_last_pre[b] = FAR;
        end
        m_last_ref = FAR; m_last_rw = FAR; m_cl = CL_DEFAULT;
        for (int i = 0; i < MAXC; i++) begin
            e_strb[i] = 0; e_err[i] = 0; e_rdv[i] = 0; e_wrv[i] = 0;
            e_rba[i] = 0; e_rrow[i] = 0; e_rcol[i] = 0;
            e_wba[i] = 0; e_wrow[i] = 0; e_wcol[i] = 0;
        end
    endtask

    task automatic sched(input bit rd, input int e, input int ba, input int row, input int col);
        for (int j = 0; j < 2; j++) begin
            if (e + j < MAXC) begin
                if (rd) begin
                    e_rdv[e+j] = 1; e_rba[e+j] = ba; e_rrow[e+j] = row;
                    e_rcol[e+j] = (j == 0) ? col : (col ^ 2);
                end else begin
                    e_wrv[e+j] = 1; e_wba[e+j] = ba; e_wrow[e+j] = row;
                    e_wcol[e+j] = (j == 0) ? col : (col ^ 2);
                end
            end
        end
    endtask

    // Command c sampled at edge n; legality judged from elapsed time since past commands.
    task automatic model_cmd(input int n, input int c, input int ba, input int a);
        int err;
        int cl_f;
        bit all;
        err = 0;
        cl_f = (a >> 4) & 7;
        all = ((a >> 10) & 1) == 1;
        if (c != C_NOP && n - m_last_ref < T_RFC) err = 7;
        else begin
            case (c)
                C_ACT: if (m_open[ba]) err = 1; else if (n - m_last_pre[ba] < T_RP) err = 2;
                C_RD, C_WR: begin
                    if (!m_open[ba]) err = 3;
                    else if (n - m_last_act[ba] < T_RCD) err = 4;
                    else if (n - m_last_rw < 2) err = 8;
                end
                C_PRE: for (int b = 0; b < NBANK; b++)
                    if ((all || b == ba) && m_open[b] && n - m_last_act[b] < T_RAS) err = 5;
                C_REF: for (int b = 0; b < NBANK; b++)
                    if (m_open[b] || n - m_last_pre[b] < T_RP) err = 6;
                C_MRS: if (ba == 0 && (cl_f < 3 || cl_f > 6)) err = 9;
                default: err = 0;
            endcase
        end
        e_err[n] = err;
        if (c != C_NOP && err == 0) begin
            e_strb[n] = 1 << (c - 1);
            case (c)
                C_ACT: begin m_open[ba] = 1; m_row[ba] = a; m_last_act[ba] = n; end
                C_RD: begin sched(1, n + m_cl - 1, ba, m_row[ba], a & 'h3FF); m_last_rw = n; end
                C_WR: begin sched(0, n + m_cl - 2, ba, m_row[ba], a & 'h3FF); m_last_rw = n; end
                C_PRE: for (int b = 0; b < NBANK; b++)
                    if ((all || b == ba) && m_open[b]) begin m_open[b] = 0; m_last_pre[b] = n; end
                C_REF: m_last_ref = n;
                C_MRS: if (ba == 0) m_cl = cl_f;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs(input int e);
        int xb, xr, xc;
        logic [NBANK-1:0] ob;
        check_eq("cmd_strb", cmd_strb, e_strb[e]);
        check_eq("err_valid", err_valid, e_err[e] != 0);
        check_eq("err_code", err_code, e_err[e]);
        check_eq("rd_valid", rd_valid, e_rdv[e]);
        check_eq("wr_valid", wr_valid, e_wrv[e]);
        xb = 0; xr = 0; xc = 0;
        if (e_rdv[e]) begin xb = e_rba[e]; xr = e_rrow[e]; xc = e_rcol[e]; end
        else if (e_wrv[e]) begin xb = e_wba[e]; xr = e_wrow[e]; xc = e_wcol[e]; end
        check_eq("xfer_ba", xfer_ba, xb);
        check_eq("xfer_row", xfer_row, xr);
        check_eq("xfer_col", xfer_col, xc);
        for (int b = 0; b < NBANK; b++) ob[b] = m_open[b];
        check_eq("bank_open", bank_open, ob);
        check_eq("cur_cl", cur_cl, m_cl);
    endtask

    // Called at a falling edge: drive, let the rising edge sample, check at the next fall.
    task automatic step(input int c, input int ba, input int a, input bit cke);
        logic [3:0] pins;
        case (c)
            C_ACT:   pins = 4'b0011;
            C_RD:    pins = 4'b0101;
            C_WR:    pins = 4'b0100;
            C_PRE:   pins = 4'b0010;
            C_REF:   pins = 4'b0001;
            C_MRS:   pins = 4'b0000;
            default: pins = ($urandom_range(1) == 1) ? 4'b0111 : {1'b1, 3'($urandom_range(7))};
        endcase
        ddr_cke = cke;
        {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = pins;
        ddr_ba = 3'(ba);
        ddr_a  = 14'(a);
        model_cmd(cyc + 1, cke ? c : C_NOP, ba, a);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs(cyc);
    endtask

    task automatic nops(input int k);
        for (int i = 0; i < k; i++) step(C_NOP, 0, 0, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ddr_cke = 1'b1;
        {ddr_cs_n, ddr_ras_n, ddr_cas_n, ddr_we_n} = 4'b1111;
        model_reset();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs(cyc);
    endtask

    initial begin
        int r, c, ba, a;
        bit cke;
        @(negedge clk);
        do_reset();
        check_eq("rst_cur_cl", cur_cl, 3'd4);
        check_eq("rst_bank_open", bank_open, 8'h00);

        // Basic read: ACT b2 row 0x155, RD col 0x10 three edges later, CL=4.
        step(C_ACT, 2, 'h155, 1'b1);
        check_eq("ex1_act_strb", cmd_strb, 6'b000001);
        nops(2);
        step(C_RD, 2, 'h010, 1'b1);
        nops(2);
        check_eq("ex1_rd_early", rd_valid, 1'b0);
        nops(1);
        check_eq("ex1_rd_beat0", rd_valid, 1'b1);
        check_eq("ex1_col0", xfer_col, 10'h010);
        check_eq("ex1_row", xfer_row, 14'h155);
        nops(1);
        check_eq("ex1_col1", xfer_col, 10'h012);
        nops(1);
        check_eq("ex1_rd_done", rd_valid, 1'b0);

        // tRCD and tRAS violations, then a legal precharge.
        do_reset();
        step(C_ACT, 1, 'h0AA, 1'b1);
        nops(1);
        step(C_RD, 1, 0, 1'b1);
        check_eq("ex2_err_rcd", err_code, 4'd4);
        nops(2);
        step(C_PRE, 1, 0, 1'b1);
        check_eq("ex2_err_ras", err_code, 4'd5);
        nops(2);
        step(C_PRE, 1, 0, 1'b1);
        check_eq("ex2_pre_ok", cmd_strb, 6'b001000);
        check_eq("ex2_closed", bank_open[1], 1'b0);

        // tCCD: back-to-back read rejected, reads two apart stream gap-free.
        do_reset();
        step(C_ACT, 0, 'h321, 1'b1);
        nops(9);
        step(C_RD, 0, 'h040, 1'b1);
        step(C_RD, 0, 'h044, 1'b1);
        check_eq("ex3_err_ccd", err_code, 4'd8);
        step(C_RD, 0, 'h048, 1'b1);
        for (int i = 0; i < 5; i++) begin
            nops(1);
            check_eq("ex3_stream", rd_valid, (i < 4) ? 1'b1 : 1'b0);
        end

        // MRS to CL=5, write latency, illegal CL rejected.
        do_reset();
        step(C_ACT, 4, 'h077, 1'b1);
        step(C_MRS, 0, 5 << 4, 1'b1);
        check_eq("ex4_cl5", cur_cl, 3'd5);
        nops(1);
        step(C_WR, 4, 'h021, 1'b1);
        nops(2);
        check_eq("ex4_wr_early", wr_valid, 1'b0);
        nops(1);
        check_eq("ex4_wr_beat0", wr_valid, 1'b1);
        check_eq("ex4_wr_col0", xfer_col, 10'h021);
        nops(1);
        check_eq("ex4_wr_col1", xfer_col, 10'h023);
        nops(1);
        check_eq("ex4_wr_done", wr_valid, 1'b0);
        step(C_MRS, 0, 7 << 4, 1'b1);
        check_eq("ex4_err_cl", err_code, 4'd9);
        check_eq("ex4_cl_kept", cur_cl, 3'd5);

        // Precharge-all, refresh gating by tRP, then tRFC lockout.
        do_reset();
        step(C_ACT, 0, 'h111, 1'b1);
        step(C_ACT, 3, 'h333, 1'b1);
        nops(7);
        step(C_PRE, 0, 1 << 10, 1'b1);
        check_eq("ex5_all_closed", bank_open, 8'h00);
        step(C_REF, 0, 0, 1'b1);
        check_eq("ex5_ref_rp", err_code, 4'd6);
        nops(1);
        step(C_REF, 0, 0, 1'b1);
        check_eq("ex5_ref_ok", cmd_strb, 6'b010000);
        nops(6);
        step(C_ACT, 0, 'h222, 1'b1);
        check_eq("ex5_err_rfc", err_code, 4'd7);
        nops(18);
        step(C_ACT, 0, 'h222, 1'b1);
        check_eq("ex5_act_after_rfc", cmd_strb, 6'b000001);

        // Reset with a read pending drops it; cke=0 masks commands.
        do_reset();
        step(C_ACT, 5, 'h055, 1'b1);
        nops(2);
        step(C_RD, 5, 'h008, 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            nops(1);
            check_eq("ex6_dropped", rd_valid, 1'b0);
        end
        step(C_ACT, 6, 'h066, 1'b0);
        check_eq("ex6_cke_strb", cmd_strb, 6'b000000);
        check_eq("ex6_cke_open", bank_open, 8'h00);

        // Random traffic against the reference model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(99);
            ba = $urandom_range(NBANK - 1);
            a = $urandom_range(16383);
            cke = 1'b1;
            if (r < 30) c = C_NOP;
            else if (r < 50) c = C_ACT;
            else if (r < 62) c = C_RD;
            else if (r < 74) c = C_WR;
            else if (r < 86) c = C_PRE;
            else if (r < 90) c = C_REF;
            else if (r < 96) c = C_MRS;
            else begin c = $urandom_range(C_ACT, C_MRS); cke = 1'b0; end
            if (c == C_PRE) a = (a & ~(1 << 10)) | (($urandom_range(4) == 0) ? (1 << 10) : 0);
            if (c == C_MRS) begin
                if ($urandom_range(3) != 0) ba = 0;
                a = (a & ~'h70) | ($urandom_range(2, 7) << 4);
            end
            step(c, ba, a, cke);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
